// File: rtl/adder_sched_pkg.sv
// Shared types for the adder pool scheduler: FSM state encoding and the
// {valid, id} tag that rides alongside each in-flight adder operation.
package adder_sched_pkg;

    localparam int TAG_ID_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/adder_sched_fifo.sv
// Synchronous first-word-fall-through FIFO of {id, data} with a registered
// head entry and an occupancy count used for credit accounting.
module adder_sched_fifo #(
    parameter int DEPTH  = 8,
    parameter int ID_W   = 2,
    parameter int DATA_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [ID_W-1:0]        i_id,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_pop_ready,
    output logic                   o_valid,
    output logic [ID_W-1:0]        o_id,
    output logic [DATA_W-1:0]      o_data,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ID_W + DATA_W;

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr, r_rd;
    logic [PTR_W:0]   r_count;
    logic             r_valid;
    logic [ENT_W-1:0] r_head;

    logic             w_pop;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [PTR_W:0]   w_cnt_left, w_cnt_nxt;
    logic [ENT_W-1:0] w_wdata;

    assign w_wdata    = {i_id, i_data};
    assign w_pop      = r_valid & i_pop_ready;
    assign w_rd_nxt   = r_rd + PTR_W'(w_pop);
    assign w_cnt_left = r_count - (PTR_W+1)'(w_pop);
    assign w_cnt_nxt  = w_cnt_left + (PTR_W+1)'(i_push);

    // Head register tracks the next-state head: the incoming word bypasses
    // the array when nothing older remains after this cycle's pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_head  <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            r_rd    <= w_rd_nxt;
            r_count <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != '0);
            if (i_push && w_cnt_left == '0) r_head <= w_wdata;
            else if (w_cnt_left != '0)      r_head <= r_mem[w_rd_nxt];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr] <= w_wdata;
    end

    assign o_valid = r_valid;
    assign o_id    = r_head[ENT_W-1:DATA_W];
    assign o_data  = r_head[DATA_W-1:0];
    assign o_count = r_count;

endmodule

// File: rtl/adder_pool_scheduler.sv
// Round-robin scheduler sharing one fixed-latency four-operand adder among
// NUM_REQ requesters. Define ADDER_SCHED_STATS_EN for issue/stall counters.
module adder_pool_scheduler
    import adder_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          ap_start,
    output logic                          ap_done,
    output logic                          ap_idle,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_c,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_d,
    output logic                          dp_start,
    output logic [DATA_WIDTH-1:0]         dp_a,
    output logic [DATA_WIDTH-1:0]         dp_b,
    output logic [DATA_WIDTH-1:0]         dp_c,
    output logic [DATA_WIDTH-1:0]         dp_d,
    input  logic [DATA_WIDTH-1:0]         dp_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data
`ifdef ADDER_SCHED_STATS_EN
    ,
    output logic [31:0]                   stat_issued,
    output logic [31:0]                   stat_stalled
`endif
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                r_state;
    logic                  r_done, r_idle;
    logic [ID_W-1:0]       r_last;
    logic [CNT_W-1:0]      r_inflight;
    logic                  r_iss_vld;
    logic [ID_W-1:0]       r_iss_id;
    logic [DATA_WIDTH-1:0] r_a, r_b, r_c, r_d;
    tag_t                  r_tag [LATENCY];

    logic [CNT_W-1:0]      w_fifo_count;
    logic                  w_credit, w_run, w_gnt, w_push;
    logic [ID_W-1:0]       w_gnt_id;
    tag_t                  w_tail;

    // Credit is deliberately blind to a same-cycle pop.
    assign w_credit = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < (CNT_W+1)'(FIFO_DEPTH);
    assign w_run    = (r_state == RUN) && ap_start && w_credit;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        w_gnt    = 1'b0;
        w_gnt_id = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (w_run && req_valid[(int'(r_last) + k) % NUM_REQ]) begin
                w_gnt    = 1'b1;
                w_gnt_id = ID_W'((int'(r_last) + k) % NUM_REQ);
            end
        end
    end

    assign req_ready = w_gnt ? (NUM_REQ'(1) << w_gnt_id) : '0;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_iss_vld <= 1'b0;
            r_iss_id  <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_d       <= '0;
            r_last    <= ID_W'(NUM_REQ - 1);
        end else begin
            r_iss_vld <= w_gnt;
            if (w_gnt) begin
                r_iss_id <= w_gnt_id;
                r_a      <= req_a[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
                r_b      <= req_b[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
                r_c      <= req_c[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
                r_d      <= req_d[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
                r_last   <= w_gnt_id;
            end
        end
    end

    // Tag tail lines up with dp_result LATENCY cycles after dp_start.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int k = 0; k < LATENCY; k++) r_tag[k] <= '0;
        end else begin
            r_tag[0] <= tag_t'{valid: r_iss_vld, id: TAG_ID_W'(r_iss_id)};
            for (int k = 1; k < LATENCY; k++) r_tag[k] <= r_tag[k-1];
        end
    end

    assign w_tail = r_tag[LATENCY-1];
    assign w_push = w_tail.valid;

    always_ff @(posedge ap_clk) begin
        if (ap_rst)                r_inflight <= '0;
        else if (w_gnt && !w_push) r_inflight <= r_inflight + 1'b1;
        else if (!w_gnt && w_push) r_inflight <= r_inflight - 1'b1;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_idle  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (ap_start) begin
                    r_state <= RUN;
                    r_idle  <= 1'b0;
                end
                RUN: if (!ap_start) r_state <= DRAIN;
                DRAIN: begin
                    if (ap_start) begin
                        r_state <= RUN;
                    end else if (r_inflight == '0 && w_fifo_count == '0) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_idle  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    adder_sched_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ID_W   (ID_W),
        .DATA_W (DATA_WIDTH)
    ) u_fifo (
        .i_clk       (ap_clk),
        .i_rst       (ap_rst),
        .i_push      (w_push),
        .i_id        (w_tail.id[ID_W-1:0]),
        .i_data      (dp_result),
        .i_pop_ready (rsp_ready),
        .o_valid     (rsp_valid),
        .o_id        (rsp_id),
        .o_data      (rsp_data),
        .o_count     (w_fifo_count)
    );

    assign ap_done  = r_done;
    assign ap_idle  = r_idle;
    assign dp_start = r_iss_vld;
    assign dp_a     = r_a;
    assign dp_b     = r_b;
    assign dp_c     = r_c;
    assign dp_d     = r_d;

`ifdef ADDER_SCHED_STATS_EN
    logic [31:0] r_issued, r_stalled;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_issued  <= '0;
            r_stalled <= '0;
        end else begin
            if (w_gnt && !(&r_issued)) r_issued <= r_issued + 1'b1;
            if ((r_state == RUN) && ap_start && (|req_valid) && !w_credit && !(&r_stalled))
                r_stalled <= r_stalled + 1'b1;
        end
    end

    assign stat_issued  = r_issued;
    assign stat_stalled = r_stalled;
`endif

endmodule

// File: tb/tb_adder_pool_scheduler.sv
// Bench for adder_pool_scheduler: behavioural pipelined adder, grant-time
// scoreboard, a single-op vector table and multi-cycle corner sequences.
module tb_adder_pool_scheduler;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int L  = 4;
    localparam int D  = 8;
    localparam int IW = 2;

    logic            ap_clk = 1'b0;
    logic            ap_rst = 1'b1;
    logic            ap_start = 1'b0;
    logic            ap_done, ap_idle;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a = '0, req_b = '0, req_c = '0, req_d = '0;
    logic            dp_start;
    logic [W-1:0]    dp_a, dp_b, dp_c, dp_d, dp_result;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [IW-1:0]   rsp_id;
    logic [W-1:0]    rsp_data;
`ifdef ADDER_SCHED_STATS_EN
    logic [31:0]     stat_issued, stat_stalled;
`endif

    adder_pool_scheduler #(.NUM_REQ(N), .DATA_WIDTH(W), .LATENCY(L), .FIFO_DEPTH(D)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
        .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef ADDER_SCHED_STATS_EN
        , .stat_issued(stat_issued), .stat_stalled(stat_stalled)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    // Free-running II=1 adder; result appears L cycles after its operands.
    logic [W-1:0] add_pipe [L];
    always @(posedge ap_clk) begin
        add_pipe[0] <= dp_a + dp_b + dp_c + dp_d;
        for (int k = 1; k < L; k++) add_pipe[k] <= add_pipe[k-1];
    end
    assign dp_result = add_pipe[L-1];

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int errors = 0, checks = 0, n_gnt = 0, n_rsp = 0;

    typedef struct packed { logic [IW-1:0] id; logic [W-1:0] data; } exp_t;
    exp_t sbq[$];

    function automatic logic [W-1:0] sum_of(input int i);
        return req_a[i*W +: W] + req_b[i*W +: W] + req_c[i*W +: W] + req_d[i*W +: W];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected sum captured at grant, compared on response pop.
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            sbq.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sbq.push_back({IW'(i), sum_of(i)});
                    n_gnt++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                exp_t e;
                checks++;
                n_rsp++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got id=%0d data=%0h expected no response", rsp_id, rsp_data);
                end else begin
                    e = sbq.pop_front();
                    if (rsp_id !== e.id || rsp_data !== e.data) begin
                        errors++;
                        $display("FAIL sb_rsp: got id=%0d data=%0h expected id=%0d data=%0h",
                                 rsp_id, rsp_data, e.id, e.data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int k = 0;
        while ((sbq.size() != 0 || rsp_valid) && k < bound) begin
            @(negedge ap_clk);
            k++;
        end
        chk(name, 64'(k < bound), 64'd1);
        step();
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = $urandom;
            req_b[i*W +: W] = $urandom;
            req_c[i*W +: W] = $urandom;
            req_d[i*W +: W] = $urandom;
        end
    endtask

    typedef struct { int id; logic [W-1:0] a, b, c, d, sum; } vec_t;
    vec_t tbl [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, g, r0, g0, dones, k, seen_ready, seen_rsp, nxt;

        tbl[0] = '{2, 32'd1, 32'd2, 32'd3, 32'd4, 32'd10};
        tbl[1] = '{0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0};
        tbl[2] = '{3, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd6, 32'd11};
        tbl[3] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
        tbl[4] = '{1, 32'd100, 32'd200, 32'd300, 32'd400, 32'd1000};

        // Reset values, with requests pending to prove no grant leaks out.
        req_valid = '1;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_done", ap_done, 0);
        chk("rst_idle", ap_idle, 1);
        chk("rst_ready", req_ready, 0);
        chk("rst_dp_start", dp_start, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        step();
        ap_rst = 0;
        req_valid = '0;
        step();
        ap_start = 1;
        step();

        // Single-op vectors: issue latency, result latency, id and sum.
        foreach (tbl[v]) begin
            req_a[tbl[v].id*W +: W] = tbl[v].a;
            req_b[tbl[v].id*W +: W] = tbl[v].b;
            req_c[tbl[v].id*W +: W] = tbl[v].c;
            req_d[tbl[v].id*W +: W] = tbl[v].d;
            req_valid = N'(1) << tbl[v].id;
            @(negedge ap_clk);
            chk("vec_grant", req_ready, N'(1) << tbl[v].id);
            t0 = cyc;
            step();
            req_valid = '0;
            @(negedge ap_clk);
            chk("vec_dp_start", dp_start, 1);
            chk("vec_dp_a", dp_a, tbl[v].a);
            k = 0;
            while (!rsp_valid && k < 20) begin
                @(negedge ap_clk);
                k++;
            end
            chk("vec_latency", cyc - t0, 2 + L);
            chk("vec_rsp_id", rsp_id, tbl[v].id);
            chk("vec_rsp_data", rsp_data, tbl[v].sum);
            step();
        end

        // Fairness: all requesters valid, one grant per cycle in rotation.
        rand_ops();
        req_valid = '1;
        nxt = (tbl[4].id + 1) % N;
        for (int i = 0; i < 12; i++) begin
            @(negedge ap_clk);
            chk("rr_grant", req_ready, N'(1) << nxt);
            nxt = (nxt + 1) % N;
            step();
        end
        req_valid = '0;
        wait_drain("rr_drain", 40);

        // Back-pressure: credit stops grants at FIFO depth, then resumes.
        rand_ops();
        rsp_ready = 0;
        req_valid = '1;
        g = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ap_clk);
            if (|req_ready) g++;
            step();
        end
        chk("bp_grants", g, D);
        @(negedge ap_clk);
        chk("bp_ready_zero", req_ready, 0);
        chk("bp_rsp_held", rsp_valid, 1);
        step();
        rsp_ready = 1;
        repeat (8) step();
        req_valid = '0;
        wait_drain("bp_drain", 60);
        chk("bp_count", n_rsp, n_gnt);

        // Drain: three ops in flight, then ap_start drops.
        rand_ops();
        req_valid = '1;
        r0 = n_rsp;
        g0 = n_gnt;
        repeat (3) begin
            @(negedge ap_clk);
            step();
        end
        ap_start = 0;
        dones = 0;
        seen_ready = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge ap_clk);
            if (|req_ready) seen_ready++;
            if (ap_done) begin
                dones++;
                chk("drain_idle_at_done", ap_idle, 1);
            end
        end
        step();
        chk("drain_no_grant", seen_ready, 0);
        chk("drain_grants", n_gnt - g0, 3);
        chk("drain_rsps", n_rsp - r0, 3);
        chk("drain_done_once", dones, 1);
        chk("drain_idle", ap_idle, 1);

        // Reset with four ops in flight.
        rand_ops();
        ap_start = 1;
        repeat (5) begin
            @(negedge ap_clk);
            step();
        end
        chk("mid_inflight", n_gnt - g0, 7);
        ap_rst = 1;
        step();
        @(negedge ap_clk);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_dp_start", dp_start, 0);
        chk("mid_rst_dp_b", dp_b, 0);
        chk("mid_rst_idle", ap_idle, 1);
        chk("mid_rst_done", ap_done, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        step();
        ap_rst = 0;
        ap_start = 0;
        seen_rsp = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge ap_clk);
            if (rsp_valid) seen_rsp++;
        end
        chk("mid_no_rsp_after_rst", seen_rsp, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_pool_scheduler.md
# adder_pool_scheduler

Shares one fixed-latency, II=1 pipelined four-operand adder (the generated `a+b+c+d` datapath) among `NUM_REQ` requesters. Each cycle a round-robin arbiter grants at most one requester and drives the adder's start and operand inputs. A tag shift register tracks every in-flight operation so each sum returns with its requester ID. Results land in a credit-protected output FIFO, so downstream back-pressure never overruns the non-stallable pipeline.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; minimum 2.
- `DATA_WIDTH`, 32: operand and result width.
- `LATENCY`, 4: cycles from `dp_start` high to `dp_result` valid.
- `FIFO_DEPTH`, 8: output FIFO entries; must be a power of 2 and ≥ `LATENCY`+2.

Ports:
- `ap_clk`, in, 1: clock.
- `ap_rst`, in, 1: synchronous, active-high reset.
- `ap_start`, in, 1: enable; a level, held high while the pool is to run.
- `ap_done`, out, 1: one-cycle pulse when a drain completes.
- `ap_idle`, out, 1: high in the IDLE state.
- `req_valid`, in, `NUM_REQ`: per-requester request.
- `req_ready`, out, `NUM_REQ`: one-hot grant (or all zero).
- `req_a`, `req_b`, `req_c`, `req_d`, in, `NUM_REQ*DATA_WIDTH`: packed operands; requester i occupies slice i.
- `dp_start`, out, 1: issue strobe to the adder.
- `dp_a`, `dp_b`, `dp_c`, `dp_d`, out, `DATA_WIDTH`: operands to the adder.
- `dp_result`, in, `DATA_WIDTH`: adder output.
- `rsp_valid`, out, 1: response available.
- `rsp_ready`, in, 1: consumer accepts.
- `rsp_id`, out, `$clog2(NUM_REQ)`: requester index of the response.
- `rsp_data`, out, `DATA_WIDTH`: sum.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE → RUN when `ap_start`=1.
  - RUN → DRAIN when `ap_start`=0.
  - DRAIN → RUN when `ap_start`=1.
  - DRAIN → IDLE when `inflight`=0 and the FIFO is empty. `ap_done` pulses for one cycle on this transition.
- **Grants:** issued only in RUN. In IDLE and DRAIN, `req_ready` is all zero.
- **Credit:** a grant is allowed only when `inflight + fifo_count < FIFO_DEPTH`. A FIFO pop in the same cycle is ignored (conservative).
- **Arbitration:** round-robin. The search starts at `last_grant+1` modulo `NUM_REQ`. `last_grant` updates only on a grant. Its reset value is `NUM_REQ-1`, so requester 0 has first priority.
- **Handshake:** `req_ready[i]` depends combinationally on `req_valid` and the credit. A transfer occurs when `req_valid[i] & req_ready[i]`. Requesters hold their operands until granted.
- **Issue register:** on a grant, the granted operands and ID are registered. `dp_start` and `dp_a`..`dp_d` come from registers.
- **Tag pipeline:** a tag shift register of depth `LATENCY` carries {valid, id}. When the tail is valid, {id, `dp_result`} is pushed into the FIFO. The adder's own `ap_done` is not used.
- **In-flight count:** `inflight` counts ops in the issue register plus the tag pipeline. It increments on a grant and decrements on a FIFO push; both in one cycle leaves it unchanged.
- **FIFO:** FWFT with a registered output. A pop occurs on `rsp_valid & rsp_ready`. Push and pop may happen in the same cycle, including when the FIFO is full or empty, because the credit guarantees no overflow.
- **Arithmetic:** the scheduler passes data through unchanged. Sums wrap modulo 2^`DATA_WIDTH` inside the adder.
- **Reset:** `ap_rst` clears the FSM to IDLE, `inflight`, the tag valids, the FIFO pointers and `last_grant`. Operations in flight are discarded, and any `dp_result` produced after reset is ignored.

## Timing
- **Reset values:** `ap_done`=0, `ap_idle`=1, `req_ready`=0, `dp_start`=0, `dp_a`..`dp_d`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0.
- **Issue latency:** a grant in cycle t produces `dp_start`=1 in cycle t+1.
- **Result latency:** the FIFO push occurs in cycle t+1+`LATENCY`. `rsp_valid` rises in cycle t+2+`LATENCY` when the FIFO was empty (6 cycles with defaults).
- **Throughput:** one grant per cycle while `rsp_ready`=1 and `FIFO_DEPTH` ≥ `LATENCY`+2.
- **Drain:** deassertion of `ap_start` takes effect in the same cycle; no grant occurs in the cycle `ap_start` is seen low.

## Configuration
- **`ADDER_SCHED_STATS_EN` defined:** adds 32-bit outputs `stat_issued` and `stat_stalled`.
  - `stat_issued` counts grants.
  - `stat_stalled` counts RUN cycles with any `req_valid` but no grant because of the credit.
  - Both saturate at all-ones and clear on `ap_rst`.
- **Undefined:** the ports and counters are absent; all other behaviour is identical.

## Structure
- **Package `adder_sched_pkg`:** FSM state enum (IDLE/RUN/DRAIN) and the tag struct {valid, id}.
- **Sub-module `adder_sched_fifo`:** parameterised synchronous FWFT FIFO of {id, data} with a `count` output.
- **Top level:** the arbiter, issue register, tag pipeline, credit logic and FSM live in the top module.

## Test plan
- **Single op:** `ap_start`=1, requester 2 sends 1,2,3,4 in cycle 10 → `dp_start` in cycle 11, `rsp_valid` in cycle 16 with `rsp_id`=2 and `rsp_data`=10.
- **Fairness:** all four requesters valid continuously with `rsp_ready`=1 → grant order 0,1,2,3,0,… at one grant per cycle, responses in the same order.
- **Back-pressure:** `rsp_ready`=0 and all requesters valid → exactly 8 grants, then `req_ready`=0. Raising `rsp_ready` restarts grants with no lost or duplicated responses.
- **Wrap:** operands 0xFFFFFFFF,1,0,0 → `rsp_data`=0.
- **Drain:** drop `ap_start` with 3 ops in flight → no new grants, 3 responses delivered, then `ap_done` pulses once and `ap_idle`=1.
- **Reset mid-operation:** assert `ap_rst` with 4 ops in flight → next cycle all outputs at their reset values, and no `rsp_valid` appears afterwards.
